// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the pedestrian-crossing traffic-light controller:
// state encodings, state width, lamp-vector bit positions and the Moore
// lamp decode used by the top level.
// Lamp vector layout (LAMP_W bits): car_red, car_yel, car_grn, ped_red, ped_grn.
// ---------------------------------------------------------------------------
package tl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_CAR_GRN = 3'd0,
        ST_CAR_YEL = 3'd1,
        ST_ALLRED1 = 3'd2,
        ST_PED_GRN = 3'd3,
        ST_ALLRED2 = 3'd4,
        ST_NIGHT   = 3'd5
    } tl_state_e;

    localparam int LAMP_CAR_RED = 0;
    localparam int LAMP_CAR_YEL = 1;
    localparam int LAMP_CAR_GRN = 2;
    localparam int LAMP_PED_RED = 3;
    localparam int LAMP_PED_GRN = 4;
    localparam int LAMP_W       = 5;

    // Lamp pattern for a given state. In NIGHT the car yellow follows the
    // blink register and every pedestrian lamp is dark.
    function automatic logic [LAMP_W-1:0] lamp_decode(input tl_state_e st,
                                                      input logic      blink);
        logic [LAMP_W-1:0] l;
        l = '0;
        case (st)
            ST_CAR_GRN: begin
                l[LAMP_CAR_GRN] = 1'b1;
                l[LAMP_PED_RED] = 1'b1;
            end
            ST_CAR_YEL: begin
                l[LAMP_CAR_YEL] = 1'b1;
                l[LAMP_PED_RED] = 1'b1;
            end
            ST_PED_GRN: begin
                l[LAMP_CAR_RED] = 1'b1;
                l[LAMP_PED_GRN] = 1'b1;
            end
            ST_NIGHT: begin
                l[LAMP_CAR_YEL] = blink;
            end
            default: begin
                // Both all-red phases, and the safe pattern for any
                // unexpected code.
                l[LAMP_CAR_RED] = 1'b1;
                l[LAMP_PED_RED] = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// ---------------------------------------------------------------------------
// tl_phase_timer
// Loadable down-counter that measures phase durations in steps.
// A load has priority over counting; the counter stops at zero, and a step
// that arrives while it is already zero is reported as expiry.
// Ports:
//   clk_i      in   system clock
//   reset_i    in   asynchronous active-high reset (count <- RST_VAL)
//   load_i     in   load load_val_i this cycle
//   load_val_i in   CNT_W value to load
//   step_i     in   time-base step (tick & enable)
//   count_o    out  current count
//   expire_o   out  step seen with count == 0 (combinational)
// ---------------------------------------------------------------------------
module tl_phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             step_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expire_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= RST_VAL;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (step_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count_o  = count_q;
    assign expire_o = step_i && (count_q == '0);

endmodule

// File: rtl/traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// traffic_light_fsm
// Pedestrian-crossing controller driven by a one-cycle tick from the
// frequency divider. Holds the phase FSM, pedestrian request latch, the
// optional night blink register and registered Moore lamp outputs.
// Optional feature: define TL_NIGHT_MODE_EN to add the night_i port and the
// blinking-yellow NIGHT state.
// Ports:
//   clk_i, reset_i (async, active high), tick_i, enable_i, ped_req_i,
//   night_i (TL_NIGHT_MODE_EN only),
//   car_red_o/car_yel_o/car_grn_o, ped_red_o/ped_grn_o lamps,
//   ped_ack_o (request pending), state_o (state code),
//   remaining_o (ticks left in phase minus 1).
// ---------------------------------------------------------------------------
module traffic_light_fsm
    import tl_pkg::*;
#(
    parameter int T_GREEN  = 8,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int T_PED    = 6,
    parameter int CNT_W    = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               tick_i,
    input  logic               enable_i,
    input  logic               ped_req_i,
`ifdef TL_NIGHT_MODE_EN
    input  logic               night_i,
`endif
    output logic               car_red_o,
    output logic               car_yel_o,
    output logic               car_grn_o,
    output logic               ped_red_o,
    output logic               ped_grn_o,
    output logic               ped_ack_o,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   remaining_o
);

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN  - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(T_PED    - 1);

    tl_state_e         state_q, state_d;
    logic              pending_q, pending_d;
    logic [LAMP_W-1:0] lamp_q;
    logic              blink_d;
`ifdef TL_NIGHT_MODE_EN
    logic              blink_q;
`endif

    logic              step;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_load_val;
    logic [CNT_W-1:0]  tmr_count;
    logic              tmr_expire;

    assign step = tick_i & enable_i;

    tl_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_ALLRED)
    ) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .step_i     (step),
        .count_o    (tmr_count),
        .expire_o   (tmr_expire)
    );

    // Next-state, timer reload and request-latch logic.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        pending_d    = pending_q;
`ifdef TL_NIGHT_MODE_EN
        blink_d      = blink_q;
`else
        blink_d      = 1'b0;
`endif

        if (step) begin
`ifdef TL_NIGHT_MODE_EN
            // Night request beats both a pending pedestrian and expiry.
            if (state_q == ST_CAR_GRN && night_i) begin
                state_d      = ST_NIGHT;
                tmr_load     = 1'b1;
                tmr_load_val = '0;
                blink_d      = 1'b1;  // first night cycle shows yellow
            end else if (state_q == ST_NIGHT) begin
                if (night_i) begin
                    blink_d = ~blink_q;
                end else begin
                    state_d      = ST_ALLRED2;
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_ALLRED;
                    blink_d      = 1'b0;
                end
            end else
`endif
            if (tmr_expire) begin
                tmr_load = 1'b1;
                case (state_q)
                    ST_CAR_GRN: begin
                        if (pending_q) begin
                            state_d      = ST_CAR_YEL;
                            tmr_load_val = LD_YELLOW;
                        end else begin
                            tmr_load_val = LD_GREEN;  // hold green
                        end
                    end
                    ST_CAR_YEL: begin
                        state_d      = ST_ALLRED1;
                        tmr_load_val = LD_ALLRED;
                    end
                    ST_ALLRED1: begin
                        state_d      = ST_PED_GRN;
                        tmr_load_val = LD_PED;
                    end
                    ST_PED_GRN: begin
                        state_d      = ST_ALLRED2;
                        tmr_load_val = LD_ALLRED;
                    end
                    ST_ALLRED2: begin
                        state_d      = ST_CAR_GRN;
                        tmr_load_val = LD_GREEN;
                    end
                    default: begin
                        // Unreachable codes recover through the clearance phase.
                        state_d      = ST_ALLRED2;
                        tmr_load_val = LD_ALLRED;
                    end
                endcase
            end
        end

        // Capture runs regardless of enable; entering PED_GRN serves the
        // request and overrides a same-cycle capture.
        if (ped_req_i && state_q != ST_PED_GRN) begin
            pending_d = 1'b1;
        end
        if (state_d == ST_PED_GRN && state_q != ST_PED_GRN) begin
            pending_d = 1'b0;
        end
    end

    // Lamps are decoded from the next state so they are registered yet still
    // change on the same edge as the state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_ALLRED2;
            pending_q <= 1'b0;
            lamp_q    <= lamp_decode(ST_ALLRED2, 1'b0);
`ifdef TL_NIGHT_MODE_EN
            blink_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            lamp_q    <= lamp_decode(state_d, blink_d);
`ifdef TL_NIGHT_MODE_EN
            blink_q   <= blink_d;
`endif
        end
    end

    assign car_red_o   = lamp_q[LAMP_CAR_RED];
    assign car_yel_o   = lamp_q[LAMP_CAR_YEL];
    assign car_grn_o   = lamp_q[LAMP_CAR_GRN];
    assign ped_red_o   = lamp_q[LAMP_PED_RED];
    assign ped_grn_o   = lamp_q[LAMP_PED_GRN];
    assign ped_ack_o   = pending_q;
    assign state_o     = state_q;
    assign remaining_o = tmr_count;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_fsm
// Directed bench for traffic_light_fsm with default parameters. Expected
// phase lengths, remaining counts and lamp patterns are written out by hand.
// Night-mode scenario is compiled only when TL_NIGHT_MODE_EN is defined.
// ---------------------------------------------------------------------------
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       tick_i;
    logic       enable_i;
    logic       ped_req_i;
`ifdef TL_NIGHT_MODE_EN
    logic       night_i;
`endif
    logic       car_red_o, car_yel_o, car_grn_o, ped_red_o, ped_grn_o, ped_ack_o;
    logic [2:0] state_o;
    logic [7:0] remaining_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    traffic_light_fsm dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .tick_i      (tick_i),
        .enable_i    (enable_i),
        .ped_req_i   (ped_req_i),
`ifdef TL_NIGHT_MODE_EN
        .night_i     (night_i),
`endif
        .car_red_o   (car_red_o),
        .car_yel_o   (car_yel_o),
        .car_grn_o   (car_grn_o),
        .ped_red_o   (ped_red_o),
        .ped_grn_o   (ped_grn_o),
        .ped_ack_o   (ped_ack_o),
        .state_o     (state_o),
        .remaining_o (remaining_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // {car_red, car_yel, car_grn, ped_red, ped_grn}
    function automatic logic [4:0] lamps_now();
        return {car_red_o, car_yel_o, car_grn_o, ped_red_o, ped_grn_o};
    endfunction

    function automatic logic [4:0] exp_lamps(input int st);
        case (st)
            0:       return 5'b00110;
            1:       return 5'b01010;
            3:       return 5'b10001;
            default: return 5'b10010;
        endcase
    endfunction

    // Walk a whole phase of dur steps, checking state, countdown and lamps
    // each cycle; exp_ack < 0 skips the ack check.
    task automatic expect_phase(input int st, input int dur, input int exp_ack, input string name);
        for (int i = 0; i < dur; i++) begin
            check({name, ".state"}, 32'(state_o), 32'(st));
            check({name, ".rem"}, 32'(remaining_o), 32'(dur - 1 - i));
            check({name, ".lamps"}, 32'(lamps_now()), 32'(exp_lamps(st)));
            if (exp_ack >= 0) check({name, ".ack"}, 32'(ped_ack_o), 32'(exp_ack));
            cyc();
        end
        $display("[TB] phase %s state=%0d len=%0d done", name, st, dur);
    endtask

    initial begin
        reset_i   = 1'b1;
        tick_i    = 1'b1;
        enable_i  = 1'b1;
        ped_req_i = 1'b0;
`ifdef TL_NIGHT_MODE_EN
        night_i   = 1'b0;
`endif
        // 1: reset values, then first step enters CAR_GRN with 7 left.
        cyc(); cyc();
        check("rst.state", 32'(state_o), 32'd4);
        check("rst.rem", 32'(remaining_o), 32'd0);
        check("rst.lamps", 32'(lamps_now()), 32'(5'b10010));
        check("rst.ack", 32'(ped_ack_o), 32'd0);
        reset_i = 1'b0;
        cyc();
        check("t1.state", 32'(state_o), 32'd0);
        check("t1.rem", 32'(remaining_o), 32'd7);
        check("t1.lamps", 32'(lamps_now()), 32'(5'b00110));
        $display("[TB] reset sequence done");

        // 2: green held without request, countdown wraps 7..0..7.
        for (int k = 1; k <= 26; k++) begin
            cyc();
            check("t2.state", 32'(state_o), 32'd0);
            check("t2.rem", 32'(remaining_o), 32'(7 - (k % 8)));
        end
        $display("[TB] green hold done, rem=%0d", remaining_o);

        // 3: one-cycle request at remaining=5, full pedestrian cycle.
        check("t3.rem5", 32'(remaining_o), 32'd5);
        ped_req_i = 1'b1;
        cyc();
        ped_req_i = 1'b0;
        check("t3.ack", 32'(ped_ack_o), 32'd1);
        check("t3.rem4", 32'(remaining_o), 32'd4);
        expect_phase(0, 5, 1, "t3.grn_tail");
        expect_phase(1, 3, 1, "t3.yel");
        expect_phase(2, 1, 1, "t3.ar1");
        expect_phase(3, 6, 0, "t3.ped");
        expect_phase(4, 1, 0, "t3.ar2");
        check("t3.back.state", 32'(state_o), 32'd0);
        check("t3.back.rem", 32'(remaining_o), 32'd7);

        // 4: request held through PED_GRN and the ALLRED2 cycle.
        ped_req_i = 1'b1;
        expect_phase(0, 8, -1, "t4.grn");
        expect_phase(1, 3, 1, "t4.yel");
        expect_phase(2, 1, 1, "t4.ar1");
        expect_phase(3, 6, 0, "t4.ped");
        expect_phase(4, 1, 0, "t4.ar2");
        ped_req_i = 1'b0;
        check("t4.reack", 32'(ped_ack_o), 32'd1);
        expect_phase(0, 8, 1, "t4.grn2");
        check("t4.to_yel", 32'(state_o), 32'd1);
        check("t4.yel_rem", 32'(remaining_o), 32'd2);

        // 5a: freeze mid-yellow at remaining=1.
        cyc();
        check("t5.rem1", 32'(remaining_o), 32'd1);
        enable_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("t5.frz.state", 32'(state_o), 32'd1);
            check("t5.frz.rem", 32'(remaining_o), 32'd1);
        end
        enable_i = 1'b1;
        cyc();
        check("t5.res.state", 32'(state_o), 32'd1);
        check("t5.res.rem", 32'(remaining_o), 32'd0);
        cyc();
        expect_phase(2, 1, 1, "t5.ar1");
        expect_phase(3, 6, 0, "t5.ped");
        expect_phase(4, 1, 0, "t5.ar2");

        // 5b: request captured while frozen; tick low also freezes.
        enable_i  = 1'b0;
        ped_req_i = 1'b1;
        cyc();
        ped_req_i = 1'b0;
        cyc(); cyc();
        check("t5b.ack", 32'(ped_ack_o), 32'd1);
        check("t5b.state", 32'(state_o), 32'd0);
        check("t5b.rem", 32'(remaining_o), 32'd7);
        enable_i = 1'b1;
        tick_i   = 1'b0;
        cyc(); cyc(); cyc();
        check("t5b.notick.rem", 32'(remaining_o), 32'd7);
        tick_i = 1'b1;
        cyc();
        check("t5b.tick.rem", 32'(remaining_o), 32'd6);
        $display("[TB] freeze scenarios done");

`ifdef TL_NIGHT_MODE_EN
        // 6: night beats pending request; yellow blinks 1,0,1.
        night_i = 1'b1;
        cyc();
        check("t6.state", 32'(state_o), 32'd5);
        check("t6.rem", 32'(remaining_o), 32'd0);
        check("t6.lamps1", 32'(lamps_now()), 32'(5'b01000));
        cyc();
        check("t6.lamps0", 32'(lamps_now()), 32'(5'b00000));
        cyc();
        check("t6.lamps1b", 32'(lamps_now()), 32'(5'b01000));
        night_i = 1'b0;
        cyc();
        check("t6.ar2.state", 32'(state_o), 32'd4);
        check("t6.ar2.rem", 32'(remaining_o), 32'd0);
        check("t6.ack_kept", 32'(ped_ack_o), 32'd1);
        cyc();
        check("t6.grn.state", 32'(state_o), 32'd0);
        check("t6.grn.rem", 32'(remaining_o), 32'd7);
        $display("[TB] night mode done");
`endif

        // Asynchronous reset mid-phase takes effect without a clock edge.
        cyc(); cyc();
        #2;
        reset_i = 1'b1;
        #1;
        check("arst.state", 32'(state_o), 32'd4);
        check("arst.rem", 32'(remaining_o), 32'd0);
        check("arst.lamps", 32'(lamps_now()), 32'(5'b10010));
        check("arst.ack", 32'(ped_ack_o), 32'd0);
        cyc();
        reset_i = 1'b0;
        cyc();
        check("arst.rel.state", 32'(state_o), 32'd0);
        check("arst.rel.rem", 32'(remaining_o), 32'd7);
        $display("[TB] async reset done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
